jpeg_spi_slave: RTL

SPI slave bridge between the JPEG encoder's byte-stream readout port and the external ESP32 host. It decodes a one-byte command per chip-select frame and either returns a status byte, sets or clears the image request, or streams encoder output bytes MSB-first. The streamed bytes are the 4-byte big-endian length header followed by the JPEG bitstream. It replaces the fixed 1-in-8 pclk read strobe with host-paced reads, pulsing the encoder's read strobe once per transferred byte.

---
 rtl/jpeg_spi_slave.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/jpeg_spi_slave.sv
// rtl/jpeg_spi_slave.sv - SPI mode-0 slave bridging the host to the JPEG encoder readout port.
// All SPI pins are oversampled in pclk; commands select status, image request control or byte streaming.
module jpeg_spi_slave #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  CMD_STATUS  = 8'h05,
  parameter logic [7:0]  CMD_START   = 8'h01,
  parameter logic [7:0]  CMD_RELEASE = 8'h02,
  parameter logic [7:0]  CMD_READ    = 8'h0B
) (
  input  logic       pclk,
  input  logic       reset_n,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic       conv_end,
  input  logic [7:0] data_out,
  output logic       data_rd,
  output logic       img_req
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_STATUS,
    S_READ,
    S_DISCARD
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_dly_q, sclk_dly_d;
  logic                   cs_dly_q, cs_dly_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             rx_shift_q, rx_shift_d;
  logic [7:0]             tx_shift_q, tx_shift_d;
  logic                   miso_q, miso_d;
  logic                   data_rd_q, data_rd_d;
  logic                   img_req_q, img_req_d;

  logic       sclk_s, cs_s, mosi_s;
  logic       rise, fall, cs_fall, byte_end, shift_out;
  logic [7:0] rx_next, status_byte;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b1;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 8'h00;
      tx_shift_q  <= 8'h00;
      miso_q      <= 1'b0;
      data_rd_q   <= 1'b0;
      img_req_q   <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_dly_q  <= sclk_dly_d;
      cs_dly_q    <= cs_dly_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      miso_q      <= miso_d;
      data_rd_q   <= data_rd_d;
      img_req_q   <= img_req_d;
    end
  end

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    sclk_dly_d  = sclk_s;
    cs_dly_d    = cs_s;
    rise        = sclk_s & ~sclk_dly_q;
    fall        = ~sclk_s & sclk_dly_q;
    cs_fall     = ~cs_s & cs_dly_q;
    byte_end    = rise && (bit_cnt_q == 3'd7);
    // The fall right after a byte boundary must keep the freshly loaded MSB on the line.
    shift_out   = fall && (bit_cnt_q != 3'd0);
    rx_next     = {rx_shift_q[6:0], mosi_s};
    status_byte = {6'b0, img_req_q, conv_end};
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    data_rd_d  = 1'b0;
    img_req_d  = img_req_q;

    if (cs_s) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            state_d    = S_CMD;
            bit_cnt_d  = 3'd0;
            tx_shift_d = 8'h00;
          end
        end
        S_CMD: begin
          if (rise) begin
            rx_shift_d = rx_next;
            bit_cnt_d  = bit_cnt_q + 3'd1;
          end
          if (byte_end) begin
            state_d    = S_DISCARD;
            tx_shift_d = 8'h00;
            if (rx_next == CMD_STATUS) begin
              state_d    = S_STATUS;
              tx_shift_d = status_byte;
            end else if (rx_next == CMD_READ) begin
              if (conv_end) begin
                state_d    = S_READ;
                tx_shift_d = data_out;
                data_rd_d  = 1'b1;
              end
            end else if (rx_next == CMD_START) begin
              img_req_d = 1'b1;
            end else if (rx_next == CMD_RELEASE) begin
              img_req_d = 1'b0;
            end
          end
        end
        S_STATUS: begin
          if (rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
          if (byte_end) begin
            tx_shift_d = status_byte;
          end else if (shift_out) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
        S_READ: begin
          if (rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
          if (byte_end) begin
            if (conv_end) begin
              tx_shift_d = data_out;
              data_rd_d  = 1'b1;
            end else begin
              tx_shift_d = 8'h00;
              state_d    = S_DISCARD;
            end
          end else if (shift_out) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
        default: begin
        end
      endcase
    end

    miso_d = ((state_q == S_STATUS) || (state_q == S_READ)) ? tx_shift_q[7] : 1'b0;
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = ~cs_sync_q[SYNC_STAGES-1];
  assign data_rd     = data_rd_q;
  assign img_req     = img_req_q;

endmodule
